// File: rtl/vga_frame_scanner.sv
// VGA raster generator: pixel-rate divider, scan counters, sync/blank decode and
// a one-pixel output register stage that keeps sync, blank and colour aligned.
module vga_frame_scanner #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Red,
  input  logic [7:0] Green,
  input  logic [7:0] Blue,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       pixel_clk,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;
  logic [9:0]       hc;
  logic [9:0]       vc;
  logic             pix_en;
  logic             h_wrap;
  logic             v_wrap;
  logic             active;
  logic             hs_n;
  logic             vs_n;

  // Decode works on the current (pre-increment) position; the output stage adds
  // the single pixel of latency.
  assign pix_en   = (div == DIV_LAST);
  assign div_next = pix_en ? '0 : div + 1'b1;
  assign h_wrap   = (hc == H_LAST);
  assign v_wrap   = (vc == V_LAST);
  assign active   = (hc < H_VIS) && (vc < V_VIS);
  assign hs_n     = !((hc >= HS_START) && (hc < HS_END));
  assign vs_n     = !((vc >= VS_START) && (vc < VS_END));

  assign DrawX      = hc;
  assign DrawY      = vc;
  assign VGA_SYNC_N = 1'b0;

  // pixel_clk is registered from the next divider value so the DAC sees a
  // glitch-free clock whose rising edge lands mid-pixel.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div       <= '0;
      pixel_clk <= 1'b0;
    end else begin
      div       <= div_next;
      pixel_clk <= (div_next >= DIV_HALF);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_en) begin
      if (h_wrap) begin
        hc <= '0;
        vc <= v_wrap ? '0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  // NOTE: sync, blank and colour share one register stage and one enable, so
  // they can never drift apart; the syncs reset to their inactive (high) level.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else if (pix_en) begin
      VGA_HS      <= hs_n;
      VGA_VS      <= vs_n;
      VGA_BLANK_N <= active;
      VGA_R       <= active ? Red   : 8'd0;
      VGA_G       <= active ? Green : 8'd0;
      VGA_B       <= active ? Blue  : 8'd0;
    end
  end

  // Evaluated every Clk so the strobe is exactly one Clk wide.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && h_wrap && v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Self-checking bench for vga_frame_scanner: two reduced-raster builds (CLK_DIV 2
// and 4) compared every Clk against an edge-count arithmetic model of the raster.
module tb_vga_frame_scanner;

  localparam int H_ACTIVE = 16;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 4;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 6;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME_PIX = H_TOTAL * V_TOTAL;
  localparam int DIV_A = 2;
  localparam int DIV_B = 4;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       pclk;
    logic       hs;
    logic       vs;
    logic       bn;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       fs;
  } scan_t;

  logic Clk;
  logic Reset;

  logic [23:0] color_tab [FRAME_PIX];

  logic [9:0] draw_x_a, draw_y_a, draw_x_b, draw_y_b;
  logic [7:0] red_a, green_a, blue_a, red_b, green_b, blue_b;
  logic [7:0] vga_r_a, vga_g_a, vga_b_a, vga_r_b, vga_g_b, vga_b_b;
  logic       pclk_a, hs_a, vs_a, bn_a, sync_n_a, fs_a;
  logic       pclk_b, hs_b, vs_b, bn_b, sync_n_b, fs_b;
  int         idx_a, idx_b;

  int errors = 0;
  int checks = 0;
  int k      = 0;   // rising Clk edges since Reset was released

  // Stand-in colour mapper: a random per-position colour table.
  assign idx_a   = int'(draw_y_a) * H_TOTAL + int'(draw_x_a);
  assign idx_b   = int'(draw_y_b) * H_TOTAL + int'(draw_x_b);
  assign red_a   = color_tab[idx_a][23:16];
  assign green_a = color_tab[idx_a][15:8];
  assign blue_a  = color_tab[idx_a][7:0];
  assign red_b   = color_tab[idx_b][23:16];
  assign green_b = color_tab[idx_b][15:8];
  assign blue_b  = color_tab[idx_b][7:0];

  vga_frame_scanner #(
    .CLK_DIV(DIV_A), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut_a (
    .Clk(Clk), .Reset(Reset), .Red(red_a), .Green(green_a), .Blue(blue_a),
    .DrawX(draw_x_a), .DrawY(draw_y_a), .pixel_clk(pclk_a), .VGA_HS(hs_a), .VGA_VS(vs_a),
    .VGA_BLANK_N(bn_a), .VGA_SYNC_N(sync_n_a), .VGA_R(vga_r_a), .VGA_G(vga_g_a),
    .VGA_B(vga_b_a), .frame_start(fs_a)
  );

  vga_frame_scanner #(
    .CLK_DIV(DIV_B), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut_b (
    .Clk(Clk), .Reset(Reset), .Red(red_b), .Green(green_b), .Blue(blue_b),
    .DrawX(draw_x_b), .DrawY(draw_y_b), .pixel_clk(pclk_b), .VGA_HS(hs_b), .VGA_VS(vs_b),
    .VGA_BLANK_N(bn_b), .VGA_SYNC_N(sync_n_b), .VGA_R(vga_r_b), .VGA_G(vga_g_b),
    .VGA_B(vga_b_b), .frame_start(fs_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Expected outputs after k edges: e pixel enables have occurred, the counters
  // show pixel e of the raster and the outputs show pixel e-1.
  function automatic scan_t model(input int edges, input int d);
    scan_t m;
    int e, pos, q, qx, qy;
    logic vis;
    e      = edges / d;
    pos    = e % FRAME_PIX;
    m      = '0;
    m.x    = 10'(pos % H_TOTAL);
    m.y    = 10'(pos / H_TOTAL);
    m.pclk = (edges % d) >= (d / 2);
    m.fs   = (edges > 0) && (edges % d == 0) && (e % FRAME_PIX == 0);
    if (e == 0) begin
      m.hs = 1'b1;
      m.vs = 1'b1;
    end else begin
      q    = (e - 1) % FRAME_PIX;
      qx   = q % H_TOTAL;
      qy   = q / H_TOTAL;
      vis  = (qx < H_ACTIVE) && (qy < V_ACTIVE);
      m.hs = !((qx >= H_ACTIVE + H_FP) && (qx < H_ACTIVE + H_FP + H_SYNC));
      m.vs = !((qy >= V_ACTIVE + V_FP) && (qy < V_ACTIVE + V_FP + V_SYNC));
      m.bn = vis;
      if (vis) begin
        m.r = color_tab[q][23:16];
        m.g = color_tab[q][15:8];
        m.b = color_tab[q][7:0];
      end
    end
    return m;
  endfunction

  function automatic scan_t sample_a();
    scan_t s;
    s.x = draw_x_a; s.y = draw_y_a; s.pclk = pclk_a; s.hs = hs_a; s.vs = vs_a;
    s.bn = bn_a; s.r = vga_r_a; s.g = vga_g_a; s.b = vga_b_a; s.fs = fs_a;
    return s;
  endfunction

  function automatic scan_t sample_b();
    scan_t s;
    s.x = draw_x_b; s.y = draw_y_b; s.pclk = pclk_b; s.hs = hs_b; s.vs = vs_b;
    s.bn = bn_b; s.r = vga_r_b; s.g = vga_g_b; s.b = vga_b_b; s.fs = fs_b;
    return s;
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_both(input string phase);
    check($sformatf("%s div2 k=%0d", phase, k), 64'(sample_a()), 64'(model(k, DIV_A)));
    check($sformatf("%s div4 k=%0d", phase, k), 64'(sample_b()), 64'(model(k, DIV_B)));
  endtask

  task automatic fill_colors();
    for (int i = 0; i < FRAME_PIX; i++) color_tab[i] = 24'($urandom);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      k++;
      @(negedge Clk);
      check_both("run");
    end
  endtask

  // Assert Reset away from the clock edge, check the asynchronous clear, hold, release.
  task automatic pulse_reset(input int hold);
    Reset = 1'b1;
    #1;
    k = 0;
    check_both("async_reset");
    fill_colors();
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      check_both("in_reset");
    end
    Reset = 1'b0;
  endtask

  int fs_count;

  initial begin
    Reset = 1'b1;
    fill_colors();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check_both("power_on");
    check("sync_n div2", 64'(sync_n_a), 64'(1'b0));
    check("sync_n div4", 64'(sync_n_b), 64'(1'b0));
    Reset = 1'b0;
    k = 0;

    // Run to mid-line (hc=10 on the CLK_DIV=2 build) and reset for 3 Clk.
    run(10 * DIV_A);
    check("mid_line hc", 64'(draw_x_a), 64'(10));
    pulse_reset(3);

    // First pixel enable lands on the CLK_DIV-th edge after release.
    run(DIV_A);
    check("first_advance div2", 64'(draw_x_a), 64'(1));
    run(DIV_B - DIV_A);
    check("first_advance div4", 64'(draw_x_b), 64'(1));

    // Three frames of the fast build, counting its frame strobes.
    fs_count = 0;
    for (int i = 0; i < 3 * FRAME_PIX * DIV_A; i++) begin
      @(posedge Clk);
      k++;
      @(negedge Clk);
      if (fs_a) fs_count++;
      check_both("frames");
    end
    check("frame_start count", 64'(fs_count), 64'(k / (FRAME_PIX * DIV_A)));

    // Random mid-frame resets of random length.
    for (int r = 0; r < 4; r++) begin
      run(int'($urandom_range(50, 1200)));
      pulse_reset(int'($urandom_range(1, 4)));
    end

    run(2 * FRAME_PIX * DIV_B + 37);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_frame_scanner.md
# vga_frame_scanner

Raster-timing and pixel-output stage for the game display. It generates the 640x480@60 Hz VGA scan position (`DrawX`, `DrawY`) consumed by `color_mapper`, and samples the mapper's combinational `Red`/`Green`/`Blue` answer one pixel later. It drives the registered, mutually aligned sync, blank and RGB signals to the VGA DAC. A once-per-frame strobe paces ball, block and level-text motion logic.

## Interface
- `CLK_DIV`, 2: system clocks per pixel (even, ≥2).
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BP`, 48: horizontal back porch.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BP`, 33: vertical back porch.

Ports:
- `Clk`  in  1  system clock (50 MHz).
- `Reset`  in  1  asynchronous, active-high reset.
- `Red`, `Green`, `Blue`  in  8 each  colour from `color_mapper` for the current `DrawX`/`DrawY`.
- `DrawX`  out  10  horizontal counter hc, 0..H_TOTAL-1.
- `DrawY`  out  10  vertical counter vc, 0..V_TOTAL-1.
- `pixel_clk`  out  1  DAC pixel clock.
- `VGA_HS`, `VGA_VS`  out  1 each  active-low syncs.
- `VGA_BLANK_N`  out  1  high while a visible pixel is on `VGA_R`/`VGA_G`/`VGA_B`.
- `VGA_SYNC_N`  out  1  constant 0.
- `VGA_R`, `VGA_G`, `VGA_B`  out  8 each  registered colour.
- `frame_start`  out  1  one-`Clk` strobe at each frame wrap.

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024.
- Divider `div` counts 0..CLK_DIV-1 and wraps. Internal `pix_en` = (div == CLK_DIV-1).
- `pixel_clk` = (div ≥ CLK_DIV/2). Its rising edge falls mid-pixel, so DAC inputs are stable when sampled.
- On `pix_en`:
  - hc increments.
  - At hc == H_TOTAL-1, hc → 0 and vc increments.
  - At vc == V_TOTAL-1 with hc wrapping, vc → 0.
- `DrawX`/`DrawY` are the hc/vc registers directly, with no added delay.
- Decode from the current (pre-increment) hc/vc:
  - active = hc < H_ACTIVE && vc < V_ACTIVE.
  - hs_n = !(H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC).
  - vs_n = !(V_ACTIVE+V_FP ≤ vc < V_ACTIVE+V_FP+V_SYNC).
- Output registers load only on `pix_en`:
  - `VGA_HS` ← hs_n; `VGA_VS` ← vs_n; `VGA_BLANK_N` ← active.
  - `VGA_R/G/B` ← active ? `Red/Green/Blue` : 0.
- Outside visible area RGB is forced to 0, whatever `color_mapper` drives.
- `frame_start` is a registered 1-`Clk` pulse in the cycle after the `pix_en` edge on which (hc,vc) goes (H_TOTAL-1,V_TOTAL-1) → (0,0).
  - Not asserted after reset until the first real wrap.

## Timing
- Reset values, applied asynchronously:
  - div, hc, vc, `DrawX`, `DrawY` = 0.
  - `pixel_clk` = 0; `frame_start` = 0.
  - `VGA_HS` = 1, `VGA_VS` = 1.
  - `VGA_BLANK_N` = 0; `VGA_R/G/B` = 0.
- Reset mid-line or mid-frame aborts the scan; after release, timing restarts at (0,0).
- First `pix_en` is the CLK_DIV-th rising `Clk` edge after `Reset` deasserts.
  - That edge registers the decode of (0,0) and advances hc to 1.
- Latency: exactly one pixel period (CLK_DIV `Clk` cycles) from `DrawX`/`DrawY` presenting a position to its colour, sync and blank appearing on the outputs.
  - HS, VS, BLANK_N and RGB are always mutually aligned.
- `color_mapper` must settle within one `Clk` period after hc/vc change.
- Line = H_TOTAL·CLK_DIV `Clk` (1600); frame = 840 000 `Clk`.
- `VGA_HS` low for H_SYNC pixel periods per line.
- `VGA_VS` low for V_SYNC·H_TOTAL pixel periods.
- `VGA_VS` edges coincide with the `VGA_HS` pixel boundary at hc=0.

## Test plan
- Reset mid-line: release reset, run to hc=300, assert `Reset` for 3 `Clk` -> all outputs at reset values within the same cycle; after release, `DrawX` reaches 1 after exactly CLK_DIV edges.
- Horizontal timing: count `pix_en` -> `VGA_HS` low for exactly 96 pixel periods; first low output is the one following the pixel where `DrawX`=656; HS falling edges 1600 `Clk` apart.
- Vertical timing and strobe: run 2 frames -> `VGA_VS` low exactly 1600 pixel periods starting after `DrawY`=490, hc=0; `frame_start` pulses 840 000 `Clk` apart, each 1 `Clk` wide, none before the first wrap.
- Blanking: hold `Red/Green/Blue`=8'hAA -> `VGA_R`=8'hAA only while `VGA_BLANK_N`=1; 640 such pixels per visible line; 0 throughout lines 480..524.
- Pipeline alignment: drive `Red` = `DrawX[7:0]` combinationally -> each output pixel equals the previous pixel's `DrawX`; first visible pixel of a line reads 8'h00, last reads 8'h7F; next pixel is 0 with `VGA_BLANK_N`=0.
- `CLK_DIV`=4 build: `pixel_clk` alternates 2 `Clk` high, 2 `Clk` low; line = 3200 `Clk`; HS low 384 `Clk`.
